// File: rtl/rtc_bus_cycle_gen.sv
// Drives one multiplexed address/data bus cycle (write or read) to the RTC chip.
// Latency 6*PH_CYC+GAP_CYC+1 cycles from start to done; start is ignored while busy.
module rtc_bus_cycle_gen #(
    parameter int PH_CYC  = 4,
    parameter int GAP_CYC = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  ad_in,
    output logic [11:0] control,
    output logic        bus_oe,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] PH_LD  = 8'(PH_CYC - 1);
    localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [11:0] ctl_q, ctl_d;
    logic        oe_q, oe_d;
    logic [7:0]  rdata_q;
    logic        busy_q, done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = A_SET;
                    cnt_d   = PH_LD;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    cnt_d = PH_LD;
                    case (state_q)
                        A_SET:   state_d = A_STB;
                        A_STB:   state_d = A_HLD;
                        A_HLD: begin
                            state_d = GAP;
                            cnt_d   = GAP_LD;
                        end
                        GAP:     state_d = D_SET;
                        D_SET:   state_d = D_STB;
                        D_STB:   state_d = D_HLD;
                        default: begin
                            state_d = DONE;
                            cnt_d   = 8'd0;
                        end
                    endcase
                end
            end
        endcase

        // Outputs are decoded from the next state so the registered copy lines up with the state.
        ctl_d = 12'hF00;
        oe_d  = 1'b0;
        case (state_d)
            A_SET, A_HLD: begin
                ctl_d = {4'b0111, addr_d};
                oe_d  = 1'b1;
            end
            A_STB: begin
                ctl_d = {4'b0100, addr_d};
                oe_d  = 1'b1;
            end
            D_SET, D_HLD: begin
                if (!rw_d) begin
                    ctl_d = {4'b1111, wdata_d};
                    oe_d  = 1'b1;
                end
            end
            D_STB: begin
                ctl_d = rw_d ? 12'h900 : {4'b1100, wdata_d};
                oe_d  = !rw_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rw_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            ctl_q   <= 12'hF00;
            oe_q    <= 1'b0;
            rdata_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctl_q   <= ctl_d;
            oe_q    <= oe_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (state_q == D_STB && cnt_q == 8'd0 && rw_q)
                rdata_q <= ad_in;
        end
    end

    assign control = ctl_q;
    assign bus_oe  = oe_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rtc_bus_cycle_gen.sv
// Directed bench for rtc_bus_cycle_gen: default timing instance plus a PH_CYC=GAP_CYC=1 instance.
module tb_rtc_bus_cycle_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, rw;
    logic [7:0]  addr, wdata, ad_in;
    logic [11:0] control;
    logic        bus_oe, busy, done;
    logic [7:0]  rdata;

    logic        reset_n2, start2, rw2;
    logic [7:0]  addr2, wdata2, ad_in2;
    logic [11:0] control2;
    logic        bus_oe2, busy2, done2;
    logic [7:0]  rdata2;

    int n_total = 0;
    int n_bad   = 0;

    rtc_bus_cycle_gen #(.PH_CYC(4), .GAP_CYC(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .ad_in(ad_in), .control(control), .bus_oe(bus_oe),
        .rdata(rdata), .busy(busy), .done(done)
    );

    rtc_bus_cycle_gen #(.PH_CYC(1), .GAP_CYC(1)) dut_fast (
        .clk(clk), .reset_n(reset_n2), .start(start2), .rw(rw2), .addr(addr2),
        .wdata(wdata2), .ad_in(ad_in2), .control(control2), .bus_oe(bus_oe2),
        .rdata(rdata2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {busy, done, bus_oe, control} for cycle c after the start cycle,
    // derived from the phase boundaries: 3 address phases, gap, 3 data phases, done.
    function automatic logic [14:0] model(input int ph, input int gap, input int c,
                                          input logic r, input logic [7:0] a,
                                          input logic [7:0] w);
        int total = 6 * ph + gap + 1;
        int t = c - 1;
        if (c < 1 || c > total) return {3'b000, 12'hF00};
        if (c == total)         return {3'b110, 12'hF00};
        if (t < ph)             return {3'b101, 4'h7, a};
        if (t < 2 * ph)         return {3'b101, 4'h4, a};
        if (t < 3 * ph)         return {3'b101, 4'h7, a};
        if (t < 3 * ph + gap)   return {3'b100, 12'hF00};
        if (t < 4 * ph + gap || t >= 5 * ph + gap)
            return r ? {3'b100, 12'hF00} : {3'b101, 4'hF, w};
        return r ? {3'b100, 12'h900} : {3'b101, 4'hC, w};
    endfunction

    // Caller is just after an edge (cycle 0). Runs to cycle 'stop', checking every cycle.
    task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] w,
                           input logic [7:0] rd_old, input logic [7:0] rd_new,
                           input bit stray, input int stop);
        logic [14:0] e;
        int n_done = 0;
        start = 1'b1; rw = r; addr = a; wdata = w;
        for (int c = 1; c <= stop; c++) begin
            @(posedge clk); #1;
            start = stray && (c == 3 || c == 33);
            if (stray) begin rw = ~r; addr = ~a; wdata = ~w; end
            ad_in = (c >= 25 && c <= 28) ? 8'h59 : 8'hAA;
            e = model(4, 8, c, r, a, w);
            chk($sformatf("ctl@%0d", c),  {20'd0, control}, {20'd0, e[11:0]});
            chk($sformatf("oe@%0d", c),   {31'd0, bus_oe},  {31'd0, e[12]});
            chk($sformatf("done@%0d", c), {31'd0, done},    {31'd0, e[13]});
            chk($sformatf("busy@%0d", c), {31'd0, busy},    {31'd0, e[14]});
            chk($sformatf("rdata@%0d", c), {24'd0, rdata},
                {24'd0, (c >= 29) ? rd_new : rd_old});
            if (done) n_done++;
        end
        start = 1'b0;
        if (stop >= 34) chk("done_count", n_done, 1);
    endtask

    initial begin
        logic [14:0] e;
        reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'hAA;
        reset_n2 = 1'b0; start2 = 1'b0; rw2 = 1'b0; addr2 = 8'h00; wdata2 = 8'h00; ad_in2 = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl",   {20'd0, control}, 32'hF00);
        chk("rst_oe",    {31'd0, bus_oe},  0);
        chk("rst_busy",  {31'd0, busy},    0);
        chk("rst_done",  {31'd0, done},    0);
        chk("rst_rdata", {24'd0, rdata},   0);
        reset_n = 1'b1; reset_n2 = 1'b1;
        @(posedge clk); #1;

        // write with stray starts at cycles 3 and 33
        run_txn(1'b0, 8'h21, 8'h45, 8'h00, 8'h00, 1'b1, 34);
        run_txn(1'b1, 8'h23, 8'h00, 8'h00, 8'h59, 1'b0, 34);
        // write must not disturb the captured read byte
        run_txn(1'b0, 8'h7E, 8'hC3, 8'h59, 8'h59, 1'b0, 34);

        // asynchronous reset at cycle 26 of a write
        run_txn(1'b0, 8'h21, 8'h45, 8'h59, 8'h59, 1'b0, 26);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ctl",   {20'd0, control}, 32'hF00);
        chk("arst_oe",    {31'd0, bus_oe},  0);
        chk("arst_busy",  {31'd0, busy},    0);
        chk("arst_rdata", {24'd0, rdata},   0);
        @(posedge clk); #1;
        chk("arst_hold_ctl", {20'd0, control}, 32'hF00);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", {31'd0, busy}, 0);
        run_txn(1'b0, 8'h0A, 8'h5C, 8'h00, 8'h00, 1'b0, 34);

        // fast instance: back-to-back write then read
        start2 = 1'b1; rw2 = 1'b0; addr2 = 8'h10; wdata2 = 8'h33;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            start2 = (c == 9);
            if (c == 9) begin rw2 = 1'b1; addr2 = 8'h11; wdata2 = 8'hEE; end
            if (c <= 9) e = model(1, 1, c, 1'b0, 8'h10, 8'h33);
            else        e = model(1, 1, c - 9, 1'b1, 8'h11, 8'hEE);
            chk($sformatf("f_ctl@%0d", c),  {20'd0, control2}, {20'd0, e[11:0]});
            chk($sformatf("f_oe@%0d", c),   {31'd0, bus_oe2},  {31'd0, e[12]});
            chk($sformatf("f_done@%0d", c), {31'd0, done2},    {31'd0, e[13]});
            chk($sformatf("f_busy@%0d", c), {31'd0, busy2},    {31'd0, e[14]});
            chk($sformatf("f_rdata@%0d", c), {24'd0, rdata2}, (c >= 16) ? 32'h5A : 32'h0);
        end
        start2 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_cycle_gen.md
Name: rtc_bus_cycle_gen

Overview:
Generates one complete multiplexed address/data bus transaction (write or read) to the external RTC chip. It produces the 12-bit control word {ad, rd, cs, wr, data[7:0]} that feeds one input of the RTC control-word multiplexer. It also owns the bus-drive enable and captures read data from the shared AD bus. Each functional unit (init, time set, time read, etc.) instantiates one copy and pulses start.

Parameters:
PH_CYC, 4, clk cycles per bus phase (setup, strobe, hold); legal range 1..256
GAP_CYC, 8, clk cycles between address phase and data phase; legal range 1..256

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
rw  in  1  1 = read, 0 = write; captured with start
addr  in  8  RTC register address; captured with start
wdata  in  8  write data; captured with start
ad_in  in  8  AD bus value as seen from the pad
control  out  12  {ad, rd, cs, wr, data[7:0]} to the control-word multiplexer
bus_oe  out  1  1 = FPGA drives the AD bus with control[7:0]
rdata  out  8  last read byte; holds until the next read completes
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse in the DONE state

Behaviour:
- Strobe polarity: ad=0 selects the address phase, ad=1 the data phase. cs, rd and wr are active-low.
- All outputs are registered.
- Reset (asynchronous, any time including mid-transaction):
  - state=IDLE, control=12'hF00 (ad=rd=cs=wr=1, data=0x00).
  - bus_oe=0, rdata=0x00, busy=0, done=0.
  - Counter and captured registers are cleared.
- Start acceptance:
  - In IDLE, start=1 latches rw, addr and wdata; the next state is A_SET.
  - start is ignored in every other state, including DONE.
- States, each with its own duration and outputs:
  - IDLE: control=F00, bus_oe=0.
  - A_SET, PH_CYC cycles: ad=0, cs=1, rd=1, wr=1, data=addr, bus_oe=1.
  - A_STB, PH_CYC cycles: ad=0, cs=0, wr=0, rd=1, data=addr, bus_oe=1.
  - A_HLD, PH_CYC cycles: ad=0, cs=1, wr=1, rd=1, data=addr, bus_oe=1.
  - GAP, GAP_CYC cycles: ad=1, cs=1, rd=1, wr=1, data=0x00, bus_oe=0.
  - D_SET, PH_CYC cycles: ad=1, cs=1, rd=1, wr=1.
    - Write: data=wdata, bus_oe=1.
    - Read: data=0x00, bus_oe=0.
  - D_STB, PH_CYC cycles: ad=1, cs=0.
    - Write: wr=0, rd=1, data=wdata, bus_oe=1.
    - Read: rd=0, wr=1, bus_oe=0.
    - Read capture: rdata<=ad_in on the last cycle of D_STB only.
  - D_HLD, PH_CYC cycles: outputs as D_SET for the same rw.
  - DONE, 1 cycle: control=F00, bus_oe=0, done=1. Always returns to IDLE.
- Phase counter:
  - 8-bit down-counter, loaded with (length−1) on entry to each timed state.
  - The state advances when the counter reads 0.
  - No wrap-around; PH_CYC=256 loads 255.
- Latency: done asserts 6*PH_CYC+GAP_CYC+1 cycles after the start cycle. Default is 33.
- busy and done timing:
  - busy rises the cycle after start is accepted.
  - busy falls on the cycle after DONE; done and busy are both 1 during DONE.
  - Back-to-back: start asserted in the first IDLE cycle after DONE is accepted, so the minimum gap between transactions is 1 IDLE cycle.
- Bus contention rule: bus_oe=0 in every cycle where rd=0.
- rdata is unchanged by write transactions.

Test Plan:
- Reset: hold reset_n=0 and toggle clk -> control=12'hF00, bus_oe=0, busy=0, done=0, rdata=0x00.
- Write (defaults): start with rw=0, addr=0x21, wdata=0x45 at cycle 0 ->
  - Cycles 1–12: data=0x21, ad=0; cs=wr=0 only in cycles 5–8.
  - Cycles 13–20: GAP.
  - Cycles 21–32: data=0x45, ad=1; wr=0 in cycles 25–28, rd stays 1.
  - Cycle 33: done=1.
- Read: start with rw=1, addr=0x23; ad_in=0x59 during D_STB, 0xAA elsewhere ->
  - rd=0 in cycles 25–28 with bus_oe=0.
  - rdata=0x59 from cycle 29 onward.
  - wr never goes low in the data phase.
- start pulses while busy (cycles 3 and 33) -> ignored; exactly one done pulse, latched fields unchanged.
- Reset mid-operation: assert reset_n=0 at cycle 26 of a write -> control=F00 and bus_oe=0 immediately (asynchronous). After release, IDLE, and a new start is accepted.
- PH_CYC=1, GAP_CYC=1: back-to-back write then read -> first done at cycle 8. The second start is accepted at cycle 9 and its done is at cycle 17.
